bram_port_arbiter: RTL

Shares the single-write/single-read block RAM between two requesters (A, B) and adds a built-in clear sequencer that zero-fills the whole array. It sits between the requester logic and the BRAM's `w1_*`/`r1_*`/`d1` ports. Its grants are combinational, so an accepted access adds no latency. The RAM's write port and read port are arbitrated independently, so one requester's write and the other's read proceed in the same cycle.

---
 rtl/bram_port_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two-requester BRAM port sharing with independent write/read round-robin and a zero-fill clear sequencer
module bram_port_arbiter #(
   parameter int BLOCKSIZE = 10,
   parameter int DW = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_a,
   input  logic                 we_a,
   input  logic [BLOCKSIZE:0]   addr_a,
   input  logic [DW-1:0]        wdata_a,
   output logic                 gnt_a,
   output logic                 rvalid_a,
   output logic [DW-1:0]        rdata_a,
   input  logic                 req_b,
   input  logic                 we_b,
   input  logic [BLOCKSIZE:0]   addr_b,
   input  logic [DW-1:0]        wdata_b,
   output logic                 gnt_b,
   output logic                 rvalid_b,
   output logic [DW-1:0]        rdata_b,
   input  logic                 clr_start,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic                 en_w1,
   output logic [BLOCKSIZE:0]   w1_addr,
   output logic [DW-1:0]        w1_din,
   output logic [BLOCKSIZE:0]   r1_addr,
   input  logic [DW-1:0]        d1
);
   localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [BLOCKSIZE:0] clr_cnt;
   logic wr_prio, rd_prio, idle, clear;
   logic wc_a, wc_b, rc_a, rc_b, ww_a, ww_b, rw_a, rw_b;
   // prio 0 favours A, 1 favours B; it only moves when both sides contend
   always_comb begin
      idle = state == IDLE;
      clear = state == CLEAR;
      wc_a = idle & req_a & we_a;
      wc_b = idle & req_b & we_b;
      rc_a = idle & req_a & ~we_a;
      rc_b = idle & req_b & ~we_b;
      ww_a = wc_a & (~wc_b | ~wr_prio);
      ww_b = wc_b & (~wc_a | wr_prio);
      rw_a = rc_a & (~rc_b | ~rd_prio);
      rw_b = rc_b & (~rc_a | rd_prio);
   end
   assign gnt_a = ww_a | rw_a;
   assign gnt_b = ww_b | rw_b;
   assign en_w1 = clear | ww_a | ww_b;
   assign w1_addr = clear ? clr_cnt : ww_a ? addr_a : ww_b ? addr_b : '0;
   assign w1_din = ww_a ? wdata_a : ww_b ? wdata_b : '0;
   assign r1_addr = rw_a ? addr_a : rw_b ? addr_b : '0;
   assign rdata_a = rvalid_a ? d1 : '0;
   assign rdata_b = rvalid_b ? d1 : '0;
   assign clr_busy = clear;
   assign clr_done = state == DONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         clr_cnt <= '0;
         wr_prio <= 1'b0;
         rd_prio <= 1'b0;
         rvalid_a <= 1'b0;
         rvalid_b <= 1'b0;
      end else begin
         if (wc_a & wc_b) wr_prio <= ~wr_prio;
         if (rc_a & rc_b) rd_prio <= ~rd_prio;
         rvalid_a <= rw_a;
         rvalid_b <= rw_b;
         state <= idle ? (clr_start ? CLEAR : IDLE) : clear ? (&clr_cnt ? DONE : CLEAR) : IDLE;
         clr_cnt <= clear ? clr_cnt + 1'b1 : '0;
      end
   end
endmodule
